// File: rtl/keyprt_host_seq.sv
// Host-side sequencer that presses keys and pops printer FIFO entries on an
// MCS-4 keyboard/printer port by driving timed command words.
module keyprt_host_seq #(
  parameter int unsigned KEY_HOLD_CYC = 50000,
  parameter int unsigned KEY_GAP_CYC  = 50000,
  parameter int unsigned POP_WAIT_CYC = 4,
  parameter int unsigned POP_HOLD_CYC = 10000,
  parameter int unsigned POP_GAP_CYC  = 10000
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        KEY_REQ,
  input  logic [6:0]  KEY_CODE,
  input  logic        POP_REQ,
  output logic        RDY,
  output logic        KEY_DONE,
  output logic        POP_VALID,
  output logic        POP_EMPTY,
  output logic [3:0]  POP_ROW,
  output logic [16:0] POP_COL,
  output logic        POP_ERR,
  output logic [31:0] PORT_KEYPRT_CMD,
  input  logic [31:0] PORT_KEYPRT_RES
);

  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [19:0] KEY_HOLD_LD = 20'(KEY_HOLD_CYC - 1);
  localparam logic [19:0] KEY_GAP_LD  = 20'(KEY_GAP_CYC - 1);
  localparam logic [19:0] POP_HOLD_LD = 20'(POP_HOLD_CYC - 1);
  localparam logic [19:0] POP_GAP_LD  = 20'(POP_GAP_CYC - 1);
  // Counter value seen during POP_ON cycle number POP_WAIT_CYC (1-based).
  localparam logic [19:0] POP_CAP_CNT = 20'(POP_HOLD_CYC - POP_WAIT_CYC);

  localparam logic [31:0] CMD_RST  = 32'h0000_0000;
  localparam logic [31:0] CMD_IDLE = 32'h8000_0000;
  localparam logic [31:0] CMD_POP  = 32'h8000_8000;

  typedef enum logic [2:0] {
    RST_W,
    IDLE,
    KEY_ON,
    KEY_OFF,
    POP_ON,
    POP_OFF
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic        rdy_q, rdy_d;
  logic        pop_valid_q;
  logic        boot_q;
  logic        capture;

  // Next-state, counter and registered-output decode; the key code is held
  // in the command register itself, so no separate code latch is needed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdy_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      RST_W: begin
        // boot_q delays the exit by one edge so RST_W spans a full cycle.
        if (boot_q) begin
          state_d = IDLE;
          cmd_d   = CMD_IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      IDLE: begin
        rdy_d = 1'b1;
        if (KEY_REQ) begin
          state_d = KEY_ON;
          cmd_d   = {1'b1, 23'b0, 1'b1, KEY_CODE};
          cnt_d   = KEY_HOLD_LD;
          rdy_d   = 1'b0;
        end else if (POP_REQ) begin
          state_d = POP_ON;
          cmd_d   = CMD_POP;
          cnt_d   = POP_HOLD_LD;
          rdy_d   = 1'b0;
        end
      end
      KEY_ON: begin
        if (cnt_q == '0) begin
          state_d = KEY_OFF;
          cmd_d   = CMD_IDLE;
          cnt_d   = KEY_GAP_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      KEY_OFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      POP_ON: begin
        capture = (cnt_q == POP_CAP_CNT);
        if (cnt_q == '0) begin
          state_d = POP_OFF;
          cmd_d   = CMD_IDLE;
          cnt_d   = POP_GAP_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      POP_OFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: begin
        state_d = RST_W;
        cmd_d   = CMD_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with counter, command, ready and the POP_VALID pulse.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q     <= RST_W;
      cnt_q       <= '0;
      cmd_q       <= CMD_RST;
      rdy_q       <= 1'b0;
      pop_valid_q <= 1'b0;
      boot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rdy_q       <= rdy_d;
      pop_valid_q <= capture;
      boot_q      <= 1'b1;
    end
  end

  // Captured POP response fields, held until the next capture.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      POP_EMPTY <= 1'b1;
      POP_ROW   <= '0;
      POP_COL   <= '0;
      POP_ERR   <= 1'b0;
    end else if (capture) begin
      POP_EMPTY <= ~PORT_KEYPRT_RES[0];
      POP_ROW   <= PORT_KEYPRT_RES[13:10];
      POP_COL   <= PORT_KEYPRT_RES[30:14];
      POP_ERR   <= ~PORT_KEYPRT_RES[31];
    end
  end

  assign PORT_KEYPRT_CMD = cmd_q;
  assign RDY             = rdy_q;
  assign POP_VALID       = pop_valid_q;
  // KEY_DONE marks the last KEY_OFF cycle; reset leaves KEY_OFF, so an
  // aborted sequence never pulses it.
  assign KEY_DONE        = (state_q == KEY_OFF) && (cnt_q == '0);

endmodule

// File: tb/tb_keyprt_host_seq.sv
// Self-checking bench for keyprt_host_seq: directed and random key/pop
// operations checked cycle by cycle against expected command timelines.
module tb_keyprt_host_seq;

  localparam int KH = 3;
  localparam int KG = 2;
  localparam int PW = 2;
  localparam int PH = 4;
  localparam int PG = 2;

  localparam logic [31:0] C_RST  = 32'h0000_0000;
  localparam logic [31:0] C_IDLE = 32'h8000_0000;
  localparam logic [31:0] C_POP  = 32'h8000_8000;

  logic        CLK = 1'b0;
  logic        RES_N;
  logic        KEY_REQ;
  logic [6:0]  KEY_CODE;
  logic        POP_REQ;
  logic        RDY;
  logic        KEY_DONE;
  logic        POP_VALID;
  logic        POP_EMPTY;
  logic [3:0]  POP_ROW;
  logic [16:0] POP_COL;
  logic        POP_ERR;
  logic [31:0] PORT_KEYPRT_CMD;
  logic [31:0] PORT_KEYPRT_RES;

  int vectors     = 0;
  int miscompares = 0;

  // Expected captured fields
  logic        exp_empty;
  logic [3:0]  exp_row;
  logic [16:0] exp_col;
  logic        exp_err;
  bit          hold_pop = 1'b0;
  bit          res_lock = 1'b0;

  keyprt_host_seq #(
    .KEY_HOLD_CYC(KH),
    .KEY_GAP_CYC (KG),
    .POP_WAIT_CYC(PW),
    .POP_HOLD_CYC(PH),
    .POP_GAP_CYC (PG)
  ) dut (
    .CLK            (CLK),
    .RES_N          (RES_N),
    .KEY_REQ        (KEY_REQ),
    .KEY_CODE       (KEY_CODE),
    .POP_REQ        (POP_REQ),
    .RDY            (RDY),
    .KEY_DONE       (KEY_DONE),
    .POP_VALID      (POP_VALID),
    .POP_EMPTY      (POP_EMPTY),
    .POP_ROW        (POP_ROW),
    .POP_COL        (POP_COL),
    .POP_ERR        (POP_ERR),
    .PORT_KEYPRT_CMD(PORT_KEYPRT_CMD),
    .PORT_KEYPRT_RES(PORT_KEYPRT_RES)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_empty = 1'b1;
    exp_row   = '0;
    exp_col   = '0;
    exp_err   = 1'b0;
  endtask

  task automatic check_outputs(input logic [31:0] cmd, input logic rdy,
                               input logic done, input logic valid);
    check("cmd", PORT_KEYPRT_CMD, cmd);
    check("rdy", {31'b0, RDY}, {31'b0, rdy});
    check("key_done", {31'b0, KEY_DONE}, {31'b0, done});
    check("pop_valid", {31'b0, POP_VALID}, {31'b0, valid});
    check("pop_empty", {31'b0, POP_EMPTY}, {31'b0, exp_empty});
    check("pop_row", {28'b0, POP_ROW}, {28'b0, exp_row});
    check("pop_col", {15'b0, POP_COL}, {15'b0, exp_col});
    check("pop_err", {31'b0, POP_ERR}, {31'b0, exp_err});
  endtask

  // Check one cycle, then throw random requests at the busy/reset sequencer.
  task automatic expect_cycle(input logic [31:0] cmd, input logic rdy,
                              input logic done, input logic valid);
    @(negedge CLK);
    check_outputs(cmd, rdy, done, valid);
    KEY_REQ  = 1'($urandom);
    KEY_CODE = 7'($urandom);
    if (!hold_pop) POP_REQ = 1'($urandom);
    if (!res_lock) PORT_KEYPRT_RES = $urandom;
  endtask

  task automatic release_reset();
    RES_N = 1'b1;
    expect_cycle(C_RST, 1'b0, 1'b0, 1'b0);
    expect_cycle(C_IDLE, 1'b1, 1'b0, 1'b0);
  endtask

  // Called at a negedge in IDLE; ends after checking the next IDLE cycle.
  task automatic key_op(input logic [6:0] code, input bit with_pop);
    logic [31:0] kcmd;
    kcmd     = 32'h8000_0080 | {25'b0, code};
    KEY_REQ  = 1'b1;
    KEY_CODE = code;
    POP_REQ  = with_pop;
    hold_pop = with_pop;
    for (int i = 1; i <= KH + KG; i++) begin
      if (i <= KH) expect_cycle(kcmd, 1'b0, 1'b0, 1'b0);
      else         expect_cycle(C_IDLE, 1'b0, (i == KH + KG), 1'b0);
    end
    expect_cycle(C_IDLE, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop_op(input logic [31:0] res);
    KEY_REQ         = 1'b0;
    POP_REQ         = 1'b1;
    PORT_KEYPRT_RES = res;
    hold_pop        = 1'b0;
    res_lock        = 1'b1;
    for (int i = 1; i <= PH + PG; i++) begin
      if (i == PW + 1) begin
        exp_empty = ~res[0];
        exp_row   = res[13:10];
        exp_col   = res[30:14];
        exp_err   = ~res[31];
      end
      expect_cycle((i <= PH) ? C_POP : C_IDLE, 1'b0, 1'b0, (i == PW + 1));
      if (i == PW + 1) res_lock = 1'b0;
    end
    expect_cycle(C_IDLE, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    RES_N           = 1'b0;
    KEY_REQ         = 1'b0;
    KEY_CODE        = '0;
    POP_REQ         = 1'b0;
    PORT_KEYPRT_RES = '0;
    model_reset();

    // Reset state, then release with one full RST_W cycle
    expect_cycle(C_RST, 1'b0, 1'b0, 1'b0);
    expect_cycle(C_RST, 1'b0, 1'b0, 1'b0);
    release_reset();

    // Directed operations
    key_op(7'h1B, 1'b0);
    pop_op(32'h8002_8401);
    pop_op(32'h0000_0000);
    key_op(7'h2A, 1'b1);
    pop_op(32'h7FFF_FFFE);
    key_op(7'h7F, 1'b0);

    // Reset pulsed in the second KEY_ON cycle
    KEY_REQ  = 1'b1;
    KEY_CODE = 7'h55;
    POP_REQ  = 1'b0;
    expect_cycle(32'h8000_00D5, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    check_outputs(32'h8000_00D5, 1'b0, 1'b0, 1'b0);
    #2 RES_N = 1'b0;
    #1 model_reset();
    check_outputs(C_RST, 1'b0, 1'b0, 1'b0);
    expect_cycle(C_RST, 1'b0, 1'b0, 1'b0);
    release_reset();

    // Random back-to-back operations
    for (int n = 0; n < 30; n++) begin
      logic [6:0]  code;
      logic [31:0] res;
      int          kind;
      code = 7'($urandom);
      res  = $urandom;
      kind = int'($urandom_range(0, 2));
      case (kind)
        0:       key_op(code, 1'b0);
        1:       pop_op(res);
        default: begin
          key_op(code, 1'b1);
          pop_op(res);
        end
      endcase
    end

    KEY_REQ = 1'b0;
    POP_REQ = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keyprt_host_seq.md
KEYPRT_HOST_SEQ -- requirements
Module: keyprt_host_seq

Interface
REQ-001: Parameter KEY_HOLD_CYC, default 50000, number of cycles a key code is driven.
REQ-002: Parameter KEY_GAP_CYC, default 50000, number of idle-command cycles after key release.
REQ-003: Parameter POP_WAIT_CYC, default 4, number of cycles from POP command assertion to response capture.
REQ-004: Parameter POP_HOLD_CYC, default 10000, total cycles the POP command is driven; must be >= POP_WAIT_CYC.
REQ-005: Parameter POP_GAP_CYC, default 10000, number of idle-command cycles after POP release.
REQ-006: Every parameter SHALL be >= 1, and each SHALL fit in the 20-bit internal counter.
REQ-007: CLK  in  1  single clock; all logic is on its rising edge.
REQ-008: RES_N  in  1  reset; asynchronous, active-low.
REQ-009: KEY_REQ  in  1  request to press a key; sampled only when RDY=1.
REQ-010: KEY_CODE  in  7  key code, latched on an accepted KEY_REQ.
REQ-011: POP_REQ  in  1  request to pop one printer FIFO entry; sampled only when RDY=1.
REQ-012: RDY  out  1  sequencer idle and able to accept a request.
REQ-013: KEY_DONE  out  1  one-cycle pulse marking the end of a key sequence.
REQ-014: POP_VALID  out  1  one-cycle pulse marking that POP_EMPTY, POP_ROW and POP_COL have been updated.
REQ-015: POP_EMPTY  out  1  captured response had RES[0]=0, meaning no FIFO data.
REQ-016: POP_ROW  out  4  captured RES[13:10].
REQ-017: POP_COL  out  17  captured RES[30:14].
REQ-018: POP_ERR  out  1  captured response had RES[31]=0, meaning the system was not ready.
REQ-019: PORT_KEYPRT_CMD  out  32  command word driven to the MCS-4 system.
REQ-020: PORT_KEYPRT_RES  in  32  response word returned by the MCS-4 system.

Function
REQ-021: The sequencer SHALL have six states: IDLE, KEY_ON, KEY_OFF, POP_ON, POP_OFF and RST_W, where RST_W is entered only by reset.
REQ-022: RST_W SHALL last exactly one cycle and drive CMD=0x0000_0000, then go to IDLE.
REQ-023: IDLE SHALL drive CMD=0x8000_0000 with RDY=1; all other states SHALL drive RDY=0.
REQ-024: In IDLE, KEY_REQ=1 SHALL latch KEY_CODE and go to KEY_ON; KEY_REQ SHALL win over a simultaneous POP_REQ.
REQ-025: In IDLE, POP_REQ=1 with KEY_REQ=0 SHALL go to POP_ON.
REQ-026: Requests that arrive while RDY=0 SHALL be ignored and not queued.
REQ-027: KEY_ON SHALL drive CMD={1'b1,23'b0,1'b1,code[6:0]} for exactly KEY_HOLD_CYC cycles, then go to KEY_OFF.
REQ-028: KEY_OFF SHALL drive CMD=0x8000_0000 for exactly KEY_GAP_CYC cycles.
REQ-029: KEY_DONE SHALL pulse in the final cycle of KEY_OFF, and the sequencer SHALL then return to IDLE.
REQ-030: POP_ON SHALL drive CMD=0x8000_8000 for exactly POP_HOLD_CYC cycles, then go to POP_OFF.
REQ-031: The POP_ON cycle count is 1-based; at the end of cycle POP_WAIT_CYC of POP_ON, RES SHALL be registered into POP_EMPTY, POP_ROW, POP_COL and POP_ERR.
REQ-032: POP_VALID SHALL be high for exactly the one cycle after that capture.
REQ-033: POP_OFF SHALL drive CMD=0x8000_0000 for exactly POP_GAP_CYC cycles, then return to IDLE.
REQ-034: CMD and RDY SHALL be registered outputs, and CMD SHALL change only on state transitions.
REQ-035: A single 20-bit down-counter SHALL be loaded with parameter-1 on each state entry, and the state SHALL exit when the counter is 0.
REQ-036: The counter SHALL never wrap around.
REQ-037: Captured POP fields SHALL hold their values until the next capture.
REQ-038: Back-to-back operation: a request asserted in the first IDLE cycle after KEY_DONE SHALL be accepted with no extra delay.

Reset
REQ-039: RES_N=0 SHALL immediately force state RST_W, CMD=0x0000_0000, RDY=0, KEY_DONE=0, POP_VALID=0, POP_EMPTY=1, POP_ROW=0, POP_COL=0, POP_ERR=0, and counter=0.
REQ-040: Reset asserted mid-sequence SHALL abort the sequence with no KEY_DONE and no POP_VALID.
REQ-041: After RES_N rises, CMD SHALL read 0x8000_0000 and RDY SHALL read 1 after exactly two clock edges.

Verification (parameters 3/2/2/4/2)
REQ-042: Release reset -> CMD=0x0000_0000 for 1 cycle, then CMD=0x8000_0000 with RDY=1.
REQ-043: KEY_REQ with code 0x1B -> CMD=0x8000_009B for 3 cycles, then CMD=0x8000_0000 for 2 cycles, KEY_DONE on the last of those cycles, then RDY=1.
REQ-044: POP_REQ with RES=0x8002_8401 -> CMD=0x8000_8000 for 4 cycles; POP_VALID after cycle 2 with ROW=1, COL=0x0000A, EMPTY=0, ERR=0.
REQ-045: POP_REQ with RES=0x0000_0000 -> POP_VALID with EMPTY=1 and ERR=1.
REQ-046: KEY_REQ and POP_REQ asserted together -> the key sequence runs first; POP_REQ held during the key sequence starts POP_ON in the cycle after RDY returns to 1.
REQ-047: RES_N pulsed low in the 2nd cycle of KEY_ON -> CMD=0x0000_0000 asynchronously, and no KEY_DONE pulse occurs.
